// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the pipeline and the multiply/divide unit.
// The pipeline side drives launches and MTHI/MTLO writes; the unit returns
// busy/done and the architectural HI/LO registers.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, mt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Signed operands are reduced to magnitudes on launch, WIDTH radix-2 steps run
// on a shared 2*WIDTH accumulator (shift-add or restoring divide), and a final
// FIX cycle restores signs and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               signed_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Launch-time operand conditioning: signed ops work on magnitudes.
  always_comb begin
    signed_op = ~bus.op[0];
    rs_neg    = signed_op & bus.rs_data[WIDTH-1];
    rt_neg    = signed_op & bus.rt_data[WIDTH-1];
    rs_mag    = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    rt_mag    = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
  end

  // One radix-2 step: upper half is partial product / remainder, lower half is multiplier / quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand});
    div_rem   = div_shift[WIDTH-1:0] - operand;
    step_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_ge) begin
        step_next = {div_rem, acc[WIDTH-2:0], 1'b1};
      end else begin
        step_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign restoration; the most-negative / -1 case falls out naturally as a positive 2^(W-1) quotient.
  always_comb begin
    prod_fix = neg_lo ? (~acc + 1'b1) : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      fix_lo = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      fix_hi = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      if (div_zero) begin
        fix_lo = {WIDTH{1'b1}};
      end
    end
  end

  // Control FSM with registered busy/done and the HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            operand  <= rt_mag;
            acc      <= {{WIDTH{1'b0}}, rs_mag};
            neg_lo   <= rs_neg ^ rt_neg;
            neg_hi   <= rs_neg;
            div_zero <= bus.op[1] & (bus.rt_data == '0);
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= CALC;
          end else begin
            if (bus.mthi) begin
              hi_q <= bus.mt_data;
            end
            if (bus.mtlo) begin
              lo_q <= bus.mt_data;
            end
          end
        end
        CALC: begin
          acc   <= step_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a cycle-level reference model (result computed in one
// shot with native arithmetic, completion after WIDTH+1 edges) is compared with
// the unit on every falling edge, and directed vectors pin the model with
// hand-computed literals.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic        m_busy;
  logic        m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  int          remaining;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    int          sa;
    int          sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        r = p;
      end
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: architectural behaviour advanced once per rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_hi      = 32'h0;
      m_lo      = 32'h0;
      remaining = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        remaining--;
        if (remaining == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = pend_hi;
          m_lo   = pend_lo;
        end
      end else if (bus.start) begin
        {pend_hi, pend_lo} = refResult(bus.op, bus.rs_data, bus.rt_data);
        m_busy    = 1'b1;
        remaining = WIDTH + 1;
      end else begin
        if (bus.mthi) m_hi = bus.mt_data;
        if (bus.mtlo) m_lo = bus.mt_data;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_busy", {31'b0, bus.busy}, {31'b0, m_busy});
      checkOutput("model_done", {31'b0, bus.done}, {31'b0, m_done});
      checkOutput("model_hi", bus.hi, m_hi);
      checkOutput("model_lo", bus.lo, m_lo);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op      = 2'($urandom);
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  task automatic waitDone(input string name, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done_seen"}, {31'b0, bus.done}, 32'h1);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus.
  initial begin
    int nb;
    int pulses;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_data = 32'h0;
    bus.rt_data = 32'h0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.mt_data = 32'h0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("reset_done", {31'b0, bus.done}, 32'h0);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] MULTU FFFFFFFF*FFFFFFFF");
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone("t1", nb);
    checkOutput("t1_busy_cycles", 32'(nb), 32'd33);
    checkOutput("t1_hi", bus.hi, 32'hFFFFFFFE);
    checkOutput("t1_lo", bus.lo, 32'h00000001);

    $display("[TB] MULT -3*7 back-to-back");
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'h00000007);
    checkOutput("t2_done_one_cycle", {31'b0, bus.done}, 32'h0);
    waitDone("t2a", nb);
    checkOutput("t2a_hi", bus.hi, 32'hFFFFFFFF);
    checkOutput("t2a_lo", bus.lo, 32'hFFFFFFEB);

    applyStimulus(2'b10, 32'hFFFFFFF9, 32'h00000002);
    waitDone("t2b", nb);
    checkOutput("t2b_hi", bus.hi, 32'hFFFFFFFF);
    checkOutput("t2b_lo", bus.lo, 32'hFFFFFFFD);

    applyStimulus(2'b10, 32'h00000007, 32'hFFFFFFFE);
    waitDone("t2c", nb);
    checkOutput("t2c_hi", bus.hi, 32'h00000001);
    checkOutput("t2c_lo", bus.lo, 32'hFFFFFFFD);

    $display("[TB] divide special cases");
    applyStimulus(2'b11, 32'h00000064, 32'h00000000);
    waitDone("t3a", nb);
    checkOutput("t3a_hi", bus.hi, 32'h00000064);
    checkOutput("t3a_lo", bus.lo, 32'hFFFFFFFF);

    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
    waitDone("t3b", nb);
    checkOutput("t3b_hi", bus.hi, 32'h00000000);
    checkOutput("t3b_lo", bus.lo, 32'h80000000);

    applyStimulus(2'b10, 32'hFFFFFFFB, 32'h00000000);
    waitDone("t3c", nb);
    checkOutput("t3c_hi", bus.hi, 32'hFFFFFFFB);
    checkOutput("t3c_lo", bus.lo, 32'hFFFFFFFF);

    $display("[TB] MTHI/MTLO");
    @(negedge clk);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h55AA55AA;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checkOutput("t4_both_hi", bus.hi, 32'h55AA55AA);
    checkOutput("t4_both_lo", bus.lo, 32'h55AA55AA);
    bus.mthi = 1'b1; bus.mt_data = 32'h12345678;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.mt_data = 32'h9ABCDEF0;
    @(negedge clk);
    bus.mtlo = 1'b0;
    checkOutput("t4_hi", bus.hi, 32'h12345678);
    checkOutput("t4_lo", bus.lo, 32'h9ABCDEF0);

    applyStimulus(2'b01, 32'h00000002, 32'h00000003);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checkOutput("t4_busy_hi", bus.hi, 32'h12345678);
    checkOutput("t4_busy_lo", bus.lo, 32'h9ABCDEF0);
    waitDone("t4", nb);
    checkOutput("t4_mul_hi", bus.hi, 32'h00000000);
    checkOutput("t4_mul_lo", bus.lo, 32'h00000006);

    $display("[TB] start wins over MT, start ignored while busy");
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'hFFFF0000;
    applyStimulus(2'b11, 32'd100, 32'd7);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checkOutput("t5_start_wins_hi", bus.hi, 32'h00000000);
    checkOutput("t5_start_wins_lo", bus.lo, 32'h00000006);
    repeat (4) @(negedge clk);
    applyStimulus(2'b01, 32'd3, 32'd3);
    waitDone("t5", nb);
    checkOutput("t5_hi", bus.hi, 32'h00000002);
    checkOutput("t5_lo", bus.lo, 32'h0000000E);

    $display("[TB] reset mid-operation");
    applyStimulus(2'b00, 32'h00001234, 32'h00005678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("t6_done", {31'b0, bus.done}, 32'h0);
    checkOutput("t6_hi", bus.hi, 32'h0);
    checkOutput("t6_lo", bus.lo, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checkOutput("t6_no_done", 32'(pulses), 32'h0);

    applyStimulus(2'b01, 32'h00010000, 32'h00010000);
    waitDone("t7", nb);
    checkOutput("t7_hi", bus.hi, 32'h00000001);
    checkOutput("t7_lo", bus.lo, 32'h00000000);
    @(negedge clk);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
